// File: rtl/midi_stream_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : midi_stream_decoder_pkg
//  Description : Shared MIDI definitions used by the stream decoder and its
//                byte classifier.
//                - status nibble codes for the channel-voice messages
//                - byte-range markers for system traffic
//                - decoder FSM state type
//                - event payload structures (note, control change, bend)
//                - helper returning the data-byte count of a status nibble
//  Revision    : 1.0  initial release
// ============================================================================
package midi_stream_decoder_pkg;

  // Natural width of a MIDI data field (7 bits, MSB of the byte is 0).
  localparam int MIDI_DATA_W = 7;

  // Channel-voice status nibbles (upper nibble of the status byte).
  localparam logic [3:0] NOTE_OFF         = 4'h8;
  localparam logic [3:0] NOTE_ON          = 4'h9;
  localparam logic [3:0] POLY_PRESSURE    = 4'hA;
  localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
  localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
  localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;
  localparam logic [3:0] PITCH_BEND       = 4'hE;

  // System byte ranges.
  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  // Encoding of the leading bit of a note_change event.
  localparam logic NOTE_EVT_OFF = 1'b0;
  localparam logic NOTE_EVT_ON  = 1'b1;

  // Decoder framing state.
  typedef enum logic [1:0] {
    DEC_IDLE    = 2'd0,
    DEC_WAIT_D1 = 2'd1,
    DEC_WAIT_D2 = 2'd2,
    DEC_SYSEX   = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic                   on;
    logic [MIDI_DATA_W-1:0] note;
    logic [MIDI_DATA_W-1:0] velocity;
  } note_change_t;

  typedef struct packed {
    logic [MIDI_DATA_W-1:0] controller;
    logic [MIDI_DATA_W-1:0] value;
  } control_change_t;

  typedef struct packed {
    logic [MIDI_DATA_W-1:0] msb;
    logic [MIDI_DATA_W-1:0] lsb;
  } pitch_bend_t;

  // Number of data bytes that follow a channel status with this nibble.
  // Program change and channel pressure carry a single byte; everything
  // else in the channel-voice range carries two.
  function automatic logic [1:0] status_data_count(input logic [3:0] nibble);
    logic [1:0] count;
    count = 2'd2;
    if (nibble == PROGRAM_CHANGE || nibble == CHANNEL_PRESSURE) begin
      count = 2'd1;
    end
    return count;
  endfunction

endpackage
`default_nettype wire

// File: rtl/midi_stream_decoder_byte_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : midi_byte_classifier
//  Description : Purely combinational classification of one MIDI byte.
//                Exactly one of the is_* flags is high for any byte.
//  Ports       : byte_in           in   8  byte to classify
//                is_realtime       out  1  0xF8-0xFF
//                is_sysex_start    out  1  0xF0
//                is_system_common  out  1  0xF1-0xF7
//                is_channel_status out  1  0x80-0xEF
//                is_data           out  1  0x00-0x7F
//                data_count        out  2  data bytes following a channel
//                                          status (0 for other classes)
//  Revision    : 1.0  initial release
// ============================================================================
module midi_byte_classifier
  import midi_stream_decoder_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_realtime,
  output logic       is_sysex_start,
  output logic       is_system_common,
  output logic       is_channel_status,
  output logic       is_data,
  output logic [1:0] data_count
);

  always_comb begin
    is_realtime       = 1'b0;
    is_sysex_start    = 1'b0;
    is_system_common  = 1'b0;
    is_channel_status = 1'b0;
    is_data           = 1'b0;
    data_count        = 2'd0;

    if (!byte_in[7]) begin
      is_data = 1'b1;
    end else if (byte_in >= REALTIME_MIN) begin
      is_realtime = 1'b1;
    end else if (byte_in == SYSEX_START) begin
      is_sysex_start = 1'b1;
    end else if (byte_in[7:4] == 4'hF) begin
      is_system_common = 1'b1;
    end else begin
      is_channel_status = 1'b1;
      data_count        = status_data_count(byte_in[7:4]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/midi_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : midi_stream_decoder
//  Description : Frames a received MIDI byte stream into channel-voice
//                messages (with running status), filters them by channel
//                and emits registered single-cycle note / control-change /
//                pitch-bend events. Real-time bytes are transparent;
//                system-exclusive payload is swallowed.
//  Ports       : clock          in   1            system clock
//                reset          in   1            synchronous, active high
//                rx_valid       in   1            rx_byte valid strobe
//                rx_byte        in   8            received byte
//                omni           in   1            accept every channel
//                channel_select in   CW           channel when omni=0
//                note_valid     out  1            note event strobe
//                note_change    out  1+2*DW       {on, note, velocity}
//                cc_valid       out  1            control-change strobe
//                control_change out  2*DW         {controller, value}
//                bend_valid     out  1            pitch-bend strobe
//                pitch_bend     out  2*DW         {msb, lsb}, centre 0x2000
//  Revision    : 1.0  initial release
// ============================================================================
module midi_stream_decoder
  import midi_stream_decoder_pkg::*;
#(
  parameter int DATA_WIDTH        = 7,
  parameter int CHANNEL_WIDTH     = 4,
  parameter int RUNNING_STATUS_EN = 1,
  parameter int PITCH_BEND_EN     = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_byte,
  input  logic                       omni,
  input  logic [CHANNEL_WIDTH-1:0]   channel_select,
  output logic                       note_valid,
  output logic [2*DATA_WIDTH:0]      note_change,
  output logic                       cc_valid,
  output logic [2*DATA_WIDTH-1:0]    control_change,
  output logic                       bend_valid,
  output logic [2*DATA_WIDTH-1:0]    pitch_bend
);

  localparam logic RS_ON   = (RUNNING_STATUS_EN != 0);
  localparam logic BEND_ON = (PITCH_BEND_EN != 0);

  // --------------------------------------------------------------------------
  // Byte classification
  // --------------------------------------------------------------------------
  logic       cls_realtime;
  logic       cls_sysex_start;
  logic       cls_system_common;
  logic       cls_channel_status;
  logic       cls_data;
  logic [1:0] cls_data_count;

  midi_byte_classifier u_classifier (
    .byte_in           (rx_byte),
    .is_realtime       (cls_realtime),
    .is_sysex_start    (cls_sysex_start),
    .is_system_common  (cls_system_common),
    .is_channel_status (cls_channel_status),
    .is_data           (cls_data),
    .data_count        (cls_data_count)
  );

  // --------------------------------------------------------------------------
  // Framing state
  // --------------------------------------------------------------------------
  dec_state_t            state;
  logic [7:0]            status_reg;   // last channel status byte
  logic                  rs_valid;     // status_reg usable for running status
  logic                  one_byte;     // status_reg message carries one byte
  logic [DATA_WIDTH-1:0] d1_reg;

  // Combinational view of what the current data byte does.
  logic                  take_d1;
  logic                  complete;
  logic [DATA_WIDTH-1:0] evt_d1;
  logic [DATA_WIDTH-1:0] evt_d2;
  logic                  chan_match;

  always_comb begin
    take_d1  = 1'b0;
    complete = 1'b0;
    evt_d1   = d1_reg;
    evt_d2   = '0;

    if (rx_valid && cls_data) begin
      case (state)
        // A data byte with no preceding status only counts when running
        // status is enabled and a channel status is still remembered.
        DEC_IDLE:    take_d1 = RS_ON && rs_valid;
        DEC_WAIT_D1: take_d1 = 1'b1;
        DEC_WAIT_D2: begin
          complete = 1'b1;
          evt_d2   = rx_byte[DATA_WIDTH-1:0];
        end
        default:     take_d1 = 1'b0;   // SysEx payload is discarded
      endcase

      if (take_d1) begin
        evt_d1   = rx_byte[DATA_WIDTH-1:0];
        complete = one_byte;
      end
    end
  end

  assign chan_match = omni || (status_reg[CHANNEL_WIDTH-1:0] == channel_select);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= DEC_IDLE;
      status_reg <= '0;
      rs_valid   <= 1'b0;
      one_byte   <= 1'b0;
      d1_reg     <= '0;
    end else if (rx_valid) begin
      if (cls_realtime) begin
        // Real-time bytes leave framing untouched.
        state <= state;
      end else if (cls_sysex_start) begin
        rs_valid <= 1'b0;
        state    <= DEC_SYSEX;
      end else if (cls_system_common) begin
        rs_valid <= 1'b0;
        state    <= DEC_IDLE;
      end else if (cls_channel_status) begin
        // A new status simply restarts framing; any partial message is lost.
        status_reg <= rx_byte;
        rs_valid   <= 1'b1;
        one_byte   <= (cls_data_count == 2'd1);
        state      <= DEC_WAIT_D1;
      end else begin
        if (take_d1) begin
          d1_reg <= rx_byte[DATA_WIDTH-1:0];
        end
        if (complete) begin
          state <= DEC_IDLE;
        end else if (take_d1) begin
          state <= DEC_WAIT_D2;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered event outputs. Payloads only change when their strobe fires.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      note_valid     <= 1'b0;
      note_change    <= '0;
      cc_valid       <= 1'b0;
      control_change <= '0;
      bend_valid     <= 1'b0;
      pitch_bend     <= '0;
    end else begin
      note_valid <= 1'b0;
      cc_valid   <= 1'b0;
      bend_valid <= 1'b0;

      if (complete && chan_match) begin
        case (status_reg[7:4])
          NOTE_ON: begin
            note_valid <= 1'b1;
            // Note-on with zero velocity is the conventional note-off.
            if (evt_d2 == '0) begin
              note_change <= {NOTE_EVT_OFF, evt_d1, {DATA_WIDTH{1'b0}}};
            end else begin
              note_change <= {NOTE_EVT_ON, evt_d1, evt_d2};
            end
          end
          NOTE_OFF: begin
            note_valid  <= 1'b1;
            note_change <= {NOTE_EVT_OFF, evt_d1, evt_d2};
          end
          CONTROL_CHANGE: begin
            cc_valid       <= 1'b1;
            control_change <= {evt_d1, evt_d2};
          end
          PITCH_BEND: begin
            if (BEND_ON) begin
              bend_valid <= 1'b1;
              pitch_bend <= {evt_d2, evt_d1};
            end
          end
          POLY_PRESSURE: begin
            // Framed for correct byte alignment, but not forwarded.
            note_valid <= 1'b0;
          end
          default: begin
            note_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/midi_stream_decoder.md
Name: midi_stream_decoder

Overview:
- Parametrised MIDI byte-stream decoder between the UART receiver and the voice/control logic.
- Accepts one received byte per valid strobe and frames channel-voice messages, including running status.
- Filters messages by channel, or accepts all channels in omni mode.
- Emits registered, single-cycle-valid note-change, control-change and pitch-bend events.
- System real-time and system-exclusive traffic is absorbed without corrupting message framing.

Parameters:
- DATA_WIDTH, 7, width of each MIDI data field.
- CHANNEL_WIDTH, 4, width of the channel field.
- RUNNING_STATUS_EN, 1, 1 = reuse the last channel status for data bytes that arrive with no status byte; 0 = drop such data bytes.
- PITCH_BEND_EN, 1, 1 = decode pitch bend messages (status high nibble 0xE); 0 = frame them but emit nothing.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_valid  input  1  rx_byte is valid this cycle; single-cycle strobe.
- rx_byte  input  8  received MIDI byte.
- omni  input  1  1 = accept all channels.
- channel_select  input  CHANNEL_WIDTH  channel to accept when omni=0.
- note_valid  output  1  single-cycle strobe.
- note_change  output  1+2*DATA_WIDTH  {status, note_number, velocity}.
- cc_valid  output  1  single-cycle strobe.
- control_change  output  2*DATA_WIDTH  {controller_number, value}.
- bend_valid  output  1  single-cycle strobe.
- pitch_bend  output  2*DATA_WIDTH  {msb, lsb}, unsigned; centre is 0x2000.

Behaviour:
- Reset:
  - All valids 0; all payloads 0.
  - FSM goes to IDLE; running status is cleared.
  - Takes effect in the same cycle as rx_valid; reset wins.
- Byte classes, all evaluated only when rx_valid=1:
  - Real-time (0xF8-0xFF): ignored completely. State, running status and any partial data byte are preserved.
  - System-exclusive start (0xF0): clear running status; go to SYSEX.
  - Other system-common (0xF1-0xF7): clear running status; go to IDLE.
  - Channel status (0x80-0xEF): latch status; data count = 1 for 0xC/0xD, otherwise 2. Go to WAIT_D1. A status byte arriving mid-message abandons the partial message silently.
  - Data byte (bit7=0): handled per state, below.
- FSM states and transitions:
  - IDLE: data byte with valid running status and RUNNING_STATUS_EN=1 is treated as D1 (go to WAIT_D2, or complete if the message takes 1 byte). Otherwise the data byte is discarded.
  - WAIT_D1: latch D1; go to WAIT_D2, or complete if the message takes 1 byte.
  - WAIT_D2: latch D2; complete.
  - SYSEX: discard data bytes. Exit on any non-real-time status byte, which is then processed normally.
- On complete:
  - Return to IDLE with running status retained.
  - If the channel matches (omni=1, or status[3:0]==channel_select), assert exactly one event valid in the next cycle, with payload registered alongside:
    - 0x9: note_change={ON, D1, D2}, except D2==0 gives {OFF, D1, 0}.
    - 0x8: note_change={OFF, D1, D2}.
    - 0xB: control_change={D1, D2}, emitted for every controller number.
    - 0xE: pitch_bend={D2, D1}, only if PITCH_BEND_EN=1.
    - 0xA, 0xC, 0xD: framed, no output.
- Latency: the event valid is high in the cycle after the final data byte's rx_valid cycle, for exactly one cycle.
- Payloads hold their last value while valids are low.
- Back-to-back rx_valid on consecutive cycles is supported; the block has no backpressure.
- omni and channel_select are sampled at completion.

Decomposition:
- Add to the shared MIDI package:
  - Status nibble constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, POLY_PRESSURE=4'hA, CONTROL_CHANGE=4'hB, PROGRAM_CHANGE=4'hC, CHANNEL_PRESSURE=4'hD, PITCH_BEND=4'hE.
  - Byte-range constants: SYSEX_START=8'hF0, REALTIME_MIN=8'hF8.
  - Types: decoder FSM state enum, pitch_bend_t struct.
  - The existing note_change_t and control_change_t are reused.
- One sub-module: midi_byte_classifier. It is combinational: byte to {is_realtime, is_sysex_start, is_system_common, is_channel_status, is_data, data_count}.

Test Plan:
- omni=1; bytes 0x90,0x3C,0x64 -> one cycle after 0x64: note_valid=1, note_change={ON,0x3C,0x64}; no other valids.
- Running status: 0x90,0x3C,0x64,0x3C,0x00 -> two note events: {ON,0x3C,0x64}, then {OFF,0x3C,0x00}.
- omni=0, channel_select=2; 0xB2,0x15,0x40 then 0xB3,0x15,0x40 -> first gives cc_valid with {0x15,0x40}; second produces no output.
- Real-time interleave: 0x90,0xF8,0x3C,0xFE,0x64 -> note_valid with {ON,0x3C,0x64}, identical timing relative to 0x64.
- SysEx and abandonment: 0xB0,0x15,0xF0,0x01,0x02,0xF7,0x40 -> no events, and running status is cleared. Then 0xE0,0x00,0x40 -> bend_valid with pitch_bend=0x2000.
- Reset mid-message: 0x90,0x3C, reset asserted, then 0x64 -> no event; all outputs 0 after reset.
